// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from execute, waits for its
// data-SRAM response, aligns/extends load data and hands the result to write-back.
module mem_stage #(
    parameter int ES_TO_MS_WD = 235,
    parameter int MS_TO_WS_WD = 195
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   es_to_ms_valid,
    input  logic [ES_TO_MS_WD-1:0] es_to_ms_data,
    output logic                   ms_allowin,
    input  logic                   ws_allowin,
    output logic                   ms_to_ws_valid,
    output logic [MS_TO_WS_WD-1:0] ms_to_ws_data,
    input  logic                   data_sram_req,
    input  logic                   data_sram_addr_ok,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   wb_ex,
    input  logic                   wb_ertn_flush,
    output logic                   ms_ex,
    output logic                   ms_ertn_flush,
    output logic [41:0]            ms_fwd_blk_data,
    output logic [14:0]            ms_csr_blk_data
);

    logic                   r_ms_valid;
    logic [ES_TO_MS_WD-1:0] r_es_data;
    logic                   r_got_data;
    logic [1:0]             r_discard_cnt;
    logic [31:0]            r_rdata_buf;

    logic        w_load_op, w_st_op, w_ale, w_res_from_mem, w_gr_we;
    logic        w_rdcntvl_w, w_rdcntvh_w;
    logic        w_ld_b, w_ld_bu, w_ld_h, w_ld_hu;
    logic [4:0]  w_dest;
    logic [31:0] w_vaddr, w_rdtimer, w_exe_result;

    assign w_load_op      = r_es_data[234];
    assign w_st_op        = r_es_data[233];
    assign w_rdcntvl_w    = r_es_data[228];
    assign w_rdcntvh_w    = r_es_data[227];
    assign w_ale          = r_es_data[208];
    assign w_rdtimer      = r_es_data[205:174];
    assign w_vaddr        = r_es_data[173:142];
    assign w_ld_b         = r_es_data[75];
    assign w_ld_bu        = r_es_data[74];
    assign w_ld_h         = r_es_data[73];
    assign w_ld_hu        = r_es_data[72];
    assign w_res_from_mem = r_es_data[70];
    assign w_gr_we        = r_es_data[69];
    assign w_dest         = r_es_data[68:64];
    assign w_exe_result   = r_es_data[63:32];

    // A response belongs to the held instruction only when no orphans are pending.
    logic w_flush, w_wait_mem, w_own_ok, w_data_avail, w_ready_go, w_capture_hold;
    assign w_flush        = wb_ex | wb_ertn_flush;
    assign w_wait_mem     = (w_load_op | w_st_op) & ~w_ale;
    assign w_own_ok       = data_sram_data_ok & (r_discard_cnt == 2'd0);
    assign w_data_avail   = r_got_data | w_own_ok;
    assign w_ready_go     = w_flush | ~w_wait_mem | w_data_avail;
    assign w_capture_hold = r_ms_valid & w_wait_mem & ~r_got_data & w_own_ok & ~ws_allowin;

    // Handshake: a transfer happens on a cycle where valid and the receiver's allowin are both high.
    assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~w_flush;

    logic [31:0] w_word, w_shift_b, w_shift_h, w_load_data, w_final_result;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_word    = r_got_data ? r_rdata_buf : data_sram_rdata;
    assign w_shift_b = w_word >> {w_vaddr[1:0], 3'b000};
    assign w_shift_h = w_word >> {w_vaddr[1], 4'b0000};
    assign w_byte    = w_shift_b[7:0];
    assign w_half    = w_shift_h[15:0];

    always_comb begin
        w_load_data = w_word;
        if (w_ld_b)       w_load_data = {{24{w_byte[7]}}, w_byte};
        else if (w_ld_bu) w_load_data = {24'd0, w_byte};
        else if (w_ld_h)  w_load_data = {{16{w_half[15]}}, w_half};
        else if (w_ld_hu) w_load_data = {16'd0, w_half};
    end

    assign w_final_result = w_res_from_mem ? w_load_data :
                            (w_rdcntvl_w | w_rdcntvh_w) ? w_rdtimer : w_exe_result;

    assign ms_to_ws_data = {r_es_data[232:206], w_vaddr, r_es_data[141], r_es_data[140],
                            r_es_data[139:108], r_es_data[107:76], w_gr_we, w_dest,
                            w_final_result, r_es_data[31:0]};

    logic w_fwd_valid, w_blk_valid;
    assign w_fwd_valid     = r_ms_valid & w_gr_we & (~w_res_from_mem | w_data_avail);
    assign w_blk_valid     = r_ms_valid & w_res_from_mem & ~w_data_avail;
    assign ms_fwd_blk_data = {{4{w_fwd_valid}}, w_dest, w_final_result, w_blk_valid};
    assign ms_ex           = r_ms_valid & r_es_data[141];
    assign ms_ertn_flush   = r_ms_valid & r_es_data[212];
    assign ms_csr_blk_data = {r_ms_valid & (r_es_data[230] | r_es_data[229] | w_rdcntvl_w | w_rdcntvh_w),
                              r_es_data[226:213]};

    // On flush, the held instruction's pending response and any request accepted
    // this cycle both become orphans that must be swallowed later.
    logic       w_orphan_own, w_orphan_req, w_discard_hit;
    logic [2:0] w_discard_sum;
    logic [1:0] w_discard_flush;
    assign w_orphan_own    = r_ms_valid & w_wait_mem & ~r_got_data & ~w_own_ok;
    assign w_orphan_req    = data_sram_req & data_sram_addr_ok;
    assign w_discard_hit   = data_sram_data_ok & (r_discard_cnt != 2'd0);
    assign w_discard_sum   = {1'b0, r_discard_cnt} + {2'b00, w_orphan_own}
                           + {2'b00, w_orphan_req} - {2'b00, w_discard_hit};
    assign w_discard_flush = (w_discard_sum > 3'd3) ? 2'd3 : w_discard_sum[1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid    <= 1'b0;
            r_es_data     <= '0;
            r_got_data    <= 1'b0;
            r_discard_cnt <= 2'd0;
            r_rdata_buf   <= 32'd0;
        end else begin
            if (w_flush)         r_ms_valid <= 1'b0;
            else if (ms_allowin) r_ms_valid <= es_to_ms_valid;

            if (es_to_ms_valid && ms_allowin) r_es_data <= es_to_ms_data;

            if (w_flush || ms_allowin) begin
                r_got_data <= 1'b0;
            end else if (w_capture_hold) begin
                r_got_data  <= 1'b1;
                r_rdata_buf <= data_sram_rdata;
            end

            if (w_flush)            r_discard_cnt <= w_discard_flush;
            else if (w_discard_hit) r_discard_cnt <= r_discard_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instructions checked
// against a field-level reference of the stage's result.
module tb_mem_stage;
  logic         clk;
  logic         resetn;
  logic         es_to_ms_valid;
  logic [234:0] es_to_ms_data;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [194:0] ms_to_ws_data;
  logic         data_sram_req;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         wb_ex;
  logic         wb_ertn_flush;
  logic         ms_ex;
  logic         ms_ertn_flush;
  logic [41:0]  ms_fwd_blk_data;
  logic [14:0]  ms_csr_blk_data;

  int total;
  int bad;
  logic [194:0] exp_q[$];

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_data(es_to_ms_data),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_data(ms_to_ws_data),
    .data_sram_req(data_sram_req), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_ex(wb_ex), .wb_ertn_flush(wb_ertn_flush),
    .ms_ex(ms_ex), .ms_ertn_flush(ms_ertn_flush),
    .ms_fwd_blk_data(ms_fwd_blk_data), .ms_csr_blk_data(ms_csr_blk_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // instruction builder: random background fields, controlled opcode fields
  // kind: 0 alu, 1 load, 2 store, 3 rdcntvl_w, 4 rdcntvh_w
  function automatic logic [234:0] make_instr(input int kind, input logic [4:0] ldsel,
                                              input logic [31:0] vaddr, input logic ale);
    logic [255:0] t;
    logic [234:0] p;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
    p = t[234:0];
    p[234] = (kind == 1);
    p[233] = (kind == 2);
    p[228] = (kind == 3);
    p[227] = (kind == 4);
    p[208] = ale;
    p[173:142] = vaddr;
    p[75:71] = (kind == 1) ? ldsel : 5'd0;
    p[70] = (kind == 1);
    return p;
  endfunction

  // reference result: plain arithmetic on the instruction's fields
  function automatic logic [31:0] ref_final(input logic [234:0] p, input logic [31:0] rd);
    int unsigned off;
    logic [31:0] b;
    logic [31:0] h;
    off = p[143:142];
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    if (p[70]) begin
      if (p[75]) return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      if (p[74]) return b;
      if (p[73]) return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      if (p[72]) return h;
      return rd;
    end
    if (p[228] || p[227]) return p[205:174];
    return p[63:32];
  endfunction

  function automatic logic [194:0] exp_out(input logic [234:0] p, input logic [31:0] rd);
    return {p[232:206], p[173:142], p[141], p[140], p[139:108], p[107:76],
            p[69], p[68:64], ref_final(p, rd), p[31:0]};
  endfunction

  // driver tasks
  task automatic send(input logic [234:0] p);
    es_to_ms_valid = 1'b1;
    es_to_ms_data = p;
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  function automatic logic [4:0] rand_ldsel();
    return 5'b10000 >> $urandom_range(0, 4);
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    es_to_ms_valid = 1'b0; es_to_ms_data = '0; ws_allowin = 1'b1;
    data_sram_req = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'd0; wb_ex = 1'b0; wb_ertn_flush = 1'b0;
    tick(); tick();
    total++; if (ms_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%0b exp=1", ms_allowin); end
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ms_to_ws_valid); end
    total++; if (ms_to_ws_data !== 195'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", ms_to_ws_data); end
    total++; if (ms_fwd_blk_data !== 42'd0) begin bad++; $display("FAIL reset_fwd got=%h exp=0", ms_fwd_blk_data); end
    total++; if (ms_csr_blk_data !== 15'd0) begin bad++; $display("FAIL reset_csr got=%h exp=0", ms_csr_blk_data); end
    total++; if ({ms_ex, ms_ertn_flush} !== 2'b00) begin bad++; $display("FAIL reset_ex got=%b exp=00", {ms_ex, ms_ertn_flush}); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_ld_b_same_cycle();
    logic [234:0] p;
    p = make_instr(1, 5'b10000, 32'h0000_1003, 1'b0);
    send(p);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL ldb_valid got=%0b exp=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_data[63:32] !== 32'hFFFF_FF80) begin bad++; $display("FAIL ldb_result got=%h exp=ffffff80", ms_to_ws_data[63:32]); end
    total++; if (ms_to_ws_data !== exp_out(p, 32'h80FF_1234)) begin bad++; $display("FAIL ldb_payload got=%h exp=%h", ms_to_ws_data, exp_out(p, 32'h80FF_1234)); end
    total++; if (ms_fwd_blk_data !== {{4{p[69]}}, p[68:64], 32'hFFFF_FF80, 1'b0}) begin bad++; $display("FAIL ldb_fwd got=%h exp=%h", ms_fwd_blk_data, {{4{p[69]}}, p[68:64], 32'hFFFF_FF80, 1'b0}); end
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL ldb_one_cycle got=%0b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_ld_hu_late();
    logic [234:0] p;
    p = make_instr(1, 5'b00010, 32'h0000_1002, 1'b0);
    send(p);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (ms_fwd_blk_data[0] !== 1'b1 || ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL ldhu_wait c=%0d blk=%0b valid=%0b exp blk=1 valid=0", c, ms_fwd_blk_data[0], ms_to_ws_valid); end
      tick();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0000;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL ldhu_valid got=%0b exp=1", ms_to_ws_valid); end
    total++; if (ms_to_ws_data[63:32] !== 32'h0000_BEEF) begin bad++; $display("FAIL ldhu_result got=%h exp=0000beef", ms_to_ws_data[63:32]); end
    total++; if (ms_fwd_blk_data[0] !== 1'b0) begin bad++; $display("FAIL ldhu_blk_drop got=%0b exp=0", ms_fwd_blk_data[0]); end
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_ws_stall();
    logic [234:0] p;
    logic [31:0] r;
    p = make_instr(1, rand_ldsel(), $urandom(), 1'b0);
    r = $urandom();
    send(p);
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = r;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin bad++; $display("FAIL stall_first valid=%0b allowin=%0b exp 1/0", ms_to_ws_valid, ms_allowin); end
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = ~r;
    #1;
    total++; if (ms_to_ws_data !== exp_out(p, r) || ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL stall_buf got=%h exp=%h", ms_to_ws_data, exp_out(p, r)); end
    tick();
    ws_allowin = 1'b1;
    #1;
    total++; if (ms_to_ws_data !== exp_out(p, r) || ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL stall_release got=%h exp=%h", ms_to_ws_data, exp_out(p, r)); end
    tick();
    #1;
    total++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin bad++; $display("FAIL stall_drain valid=%0b allowin=%0b exp 0/1", ms_to_ws_valid, ms_allowin); end
  endtask

  task automatic test_flush_discard();
    logic [234:0] p1;
    logic [234:0] p2;
    logic [31:0] good;
    p1 = make_instr(1, 5'b00001, $urandom(), 1'b0);
    p2 = make_instr(1, rand_ldsel(), $urandom(), 1'b0);
    good = $urandom();
    send(p1);
    wb_ex = 1'b1; data_sram_req = 1'b1; data_sram_addr_ok = 1'b1;
    #1;
    total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", ms_to_ws_valid); end
    tick();
    wb_ex = 1'b0; data_sram_req = 1'b0; data_sram_addr_ok = 1'b0;
    #1;
    total++; if (ms_allowin !== 1'b1 || ms_ex !== 1'b0) begin bad++; $display("FAIL flush_empty allowin=%0b ex=%0b exp 1/0", ms_allowin, ms_ex); end
    send(p2);
    for (int k = 0; k < 2; k++) begin
      data_sram_data_ok = 1'b1; data_sram_rdata = ~good;
      #1;
      total++; if (ms_to_ws_valid !== 1'b0 || ms_fwd_blk_data[0] !== p2[70]) begin bad++; $display("FAIL discard_%0d valid=%0b blk=%0b exp 0/%0b", k, ms_to_ws_valid, ms_fwd_blk_data[0], p2[70]); end
      tick();
    end
    data_sram_rdata = good;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_data !== exp_out(p2, good)) begin bad++; $display("FAIL discard_take valid=%0b got=%h exp=%h", ms_to_ws_valid, ms_to_ws_data, exp_out(p2, good)); end
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_rdcnt_ale();
    logic [234:0] p;
    p = make_instr(3, 5'd0, $urandom(), 1'b0);
    p[205:174] = 32'h0000_0042;
    send(p);
    #1;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_data[63:32] !== 32'h0000_0042) begin bad++; $display("FAIL rdcnt_result valid=%0b got=%h exp=00000042", ms_to_ws_valid, ms_to_ws_data[63:32]); end
    total++; if (ms_csr_blk_data !== {1'b1, p[226:213]}) begin bad++; $display("FAIL rdcnt_csrblk got=%h exp=%h", ms_csr_blk_data, {1'b1, p[226:213]}); end
    total++; if (ms_ertn_flush !== p[212] || ms_ex !== p[141]) begin bad++; $display("FAIL rdcnt_status ertn=%0b ex=%0b exp %0b/%0b", ms_ertn_flush, ms_ex, p[212], p[141]); end
    p = make_instr(1, 5'b00001, $urandom(), 1'b1);
    p[141] = 1'b1;
    send(p);
    #1;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_ex !== 1'b1) begin bad++; $display("FAIL ale_nowait valid=%0b ex=%0b exp 1/1", ms_to_ws_valid, ms_ex); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [234:0] p;
    logic [194:0] e;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        p = make_instr(($urandom_range(0, 1) == 0) ? 0 : 4, 5'd0, $urandom(), 1'b0);
        es_to_ms_valid = 1'b1; es_to_ms_data = p;
        exp_q.push_back(exp_out(p, 32'd0));
      end else begin
        es_to_ms_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        e = exp_q.pop_front();
        total++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || ms_to_ws_data !== e) begin bad++; $display("FAIL b2b_%0d valid=%0b got=%h exp=%h", k, ms_to_ws_valid, ms_to_ws_data, e); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [234:0] p;
    logic [31:0] r;
    logic [194:0] e;
    int kind;
    int delay;
    bit waits;
    bit done;
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 4);
      p = make_instr(kind, rand_ldsel(), $urandom(), 1'b0);
      r = $urandom();
      delay = $urandom_range(0, 3);
      waits = (kind == 1) || (kind == 2);
      exp_q.push_back(exp_out(p, r));
      send(p);
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
        data_sram_data_ok = waits && (c == delay);
        data_sram_rdata = (c == delay) ? r : $urandom();
        ws_allowin = ($urandom_range(0, 2) != 0);
        #1;
        total++; if (ms_to_ws_valid && waits && c < delay) begin bad++; $display("FAIL rand_%0d early valid at cycle %0d exp none before %0d", n, c, delay); end
        if (ms_to_ws_valid && ws_allowin) begin
          e = exp_q.pop_front();
          total++; if (ms_to_ws_data !== e) begin bad++; $display("FAIL rand_%0d kind=%0d got=%h exp=%h", n, kind, ms_to_ws_data, e); end
          done = 1'b1;
        end
        tick();
      end
      data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
      if (!done) begin
        total++; bad++;
        $display("FAIL rand_%0d timeout got=no_issue exp=issue", n);
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [234:0] p;
    logic [31:0] r;
    p = make_instr(1, 5'b00001, $urandom(), 1'b0);
    send(p);
    wb_ertn_flush = 1'b1;
    tick();
    wb_ertn_flush = 1'b0;
    p = make_instr(1, rand_ldsel(), $urandom(), 1'b0);
    send(p);
    #2;
    resetn = 1'b0;
    #1;
    total++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL rst_mid allowin=%0b valid=%0b exp 1/0", ms_allowin, ms_to_ws_valid); end
    total++; if (ms_fwd_blk_data !== 42'd0 || ms_to_ws_data !== 195'd0) begin bad++; $display("FAIL rst_mid_data fwd=%h data=%h exp 0", ms_fwd_blk_data, ms_to_ws_data); end
    tick();
    resetn = 1'b1;
    tick();
    p = make_instr(1, rand_ldsel(), $urandom(), 1'b0);
    r = $urandom();
    send(p);
    data_sram_data_ok = 1'b1; data_sram_rdata = r;
    #1;
    total++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_data !== exp_out(p, r)) begin bad++; $display("FAIL rst_discard_clear valid=%0b got=%h exp=%h", ms_to_ws_valid, ms_to_ws_data, exp_out(p, r)); end
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_ld_b_same_cycle();
    test_ld_hu_late();
    test_ws_stall();
    test_flush_discard();
    test_rdcnt_ale();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. Latches the execute stage's payload, waits for the data-SRAM response of any load/store the execute stage issued, byte/half-aligns and extends load data, and forwards the final result to write-back. Also supplies forwarding/blocking info, exception/ertn status and CSR-hazard info back to earlier stages, and drains SRAM responses orphaned by a pipeline flush.

## Interface
- ES_TO_MS_WD, 235, execute→memory payload width
- MS_TO_WS_WD, 195, memory→write-back payload width
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- es_to_ms_valid  in  1  payload valid from execute
- es_to_ms_data  in  ES_TO_MS_WD  execute payload
- ms_allowin  out  1  stage can accept
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  payload valid to write-back
- ms_to_ws_data  out  MS_TO_WS_WD  write-back payload
- data_sram_req, data_sram_addr_ok  in  1 each  request/accept as driven to/from SRAM (observed for orphan tracking)
- data_sram_data_ok  in  1  response valid
- data_sram_rdata  in  32  response data
- wb_ex, wb_ertn_flush  in  1 each  flush from write-back
- ms_ex, ms_ertn_flush  out  1 each  valid exception / ertn in this stage
- ms_fwd_blk_data  out  42  {fwd_valid[3:0], dest[4:0], data[31:0], blk_valid}
- ms_csr_blk_data  out  15  {csr_blk_valid, csr_num[13:0]}

## Operation
- Input fields: 234 load_op, 233 st_op, 232 csrxchg, 231 csrwr, 230 inst_csr, 229 rdcntid, 228 rdcntvl_w, 227 rdcntvh_w, 226:213 csr_num, 212 ertn, 211 syscall, 210 break, 209 adef, 208 ale, 207 ine, 206 has_int, 205:174 rdtimer, 173:142 vaddr, 141 ex_valid, 140 csr_we_valid, 139:108 csr_wvalue, 107:76 csr_wmask, 75..71 ld_b/ld_bu/ld_h/ld_hu/ld_w, 70 res_from_mem, 69 gr_we, 68:64 dest, 63:32 exe_result, 31:0 pc.
- Output fields: 194 csrxchg, 193 csrwr, 192 inst_csr, 191 rdcntid, 190 rdcntvl_w, 189 rdcntvh_w, 188:175 csr_num, 174 ertn, 173 syscall, 172 break, 171 adef, 170 ale, 169 ine, 168 has_int, 167:136 vaddr, 135 ex_valid, 134 csr_we_valid, 133:102 csr_wvalue, 101:70 csr_wmask, 69 gr_we, 68:64 dest, 63:32 final_result, 31:0 pc.
- wait_mem = (load_op|st_op) & !ale for latched instruction; such an instruction owns exactly one outstanding SRAM response.
- discard_cnt (2 bits): counts orphaned outstanding responses. While discard_cnt≠0, every data_ok decrements it and is ignored.
- Response captured by instruction when data_ok & discard_cnt==0 & ms_valid & wait_mem & !got_data. If ws_allowin low that cycle, rdata stored in rdata_buf, got_data←1; got_data cleared when instruction leaves.
- ms_ready_go = flush | !wait_mem | got_data | (data_ok & discard_cnt==0).
- Load data: byte = rdata[8*vaddr[1:0]+:8], half = rdata[16*vaddr[1]+:16]; ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w whole word.
- final_result = res_from_mem ? load data : (rdcntvl_w|rdcntvh_w) ? rdtimer : exe_result.
- fwd_valid = {4{ms_valid & gr_we & (!res_from_mem | data available)}}; blk_valid = ms_valid & res_from_mem & !data available; data = final_result.
- ms_ex = ms_valid & ex_valid; ms_ertn_flush = ms_valid & ertn; csr_blk_valid = ms_valid & (inst_csr|rdcntid|rdcntvl_w|rdcntvh_w).

## Timing
- Reset (resetn low, async): ms_valid, got_data, discard_cnt, rdata_buf, payload register all 0; every output 0 except ms_allowin=1.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go & !flush, flush = wb_ex|wb_ertn_flush.
- ms_valid ← 0 on flush; else ← es_to_ms_valid when ms_allowin. Payload latched on es_to_ms_valid & ms_allowin.
- Non-memory instruction: one cycle in stage. Load with data_ok in its first cycle: one cycle; otherwise leaves the cycle after data_ok (or the same cycle data_ok arrives with ws_allowin high).
- On flush edge, discard_cnt += [ms_valid & wait_mem & !got_data & !(data_ok & discard_cnt==0)] + [data_sram_req & data_sram_addr_ok] − [data_ok & discard_cnt≠0]; saturates at 3.
- data_ok on same cycle as flush: applied to discard first if discard_cnt≠0, else consumed by current instruction (no increment).

## Test plan
- ld.b, vaddr=0x1003, data_ok in same cycle, rdata=0x80FF_1234 -> final_result=0xFFFF_FF80, ms_to_ws_valid 1 cycle.
- ld.hu, vaddr=0x1002, data_ok 3 cycles late, rdata=0xBEEF_0000 -> blk_valid high 3 cycles, then final_result=0x0000_BEEF.
- Load, data_ok while ws_allowin=0 for 2 cycles -> rdata_buf holds word, result issued when ws_allowin rises, no re-wait.
- Load waiting, wb_ex pulses with an accepted EX request same cycle -> discard_cnt=2, next two data_ok ignored, following load takes third data_ok.
- rdcntvl_w with rdtimer=0x0000_0042 -> final_result=0x42, csr_blk_valid=1; ale load -> no wait, ms_ex=1.
- resetn asserted mid-wait -> all state cleared immediately, ms_allowin=1.
